// File: rtl/decap_mem_ekey_nway_if.sv
// PIO and application bus bundle for the ekey hash-table / value store.
// master drives requests, slave (the memory block) returns acks and data.
interface decap_mem_ekey_nway_if #(
  parameter int N_WAYS            = 4,
  parameter int DEPTH_NBITS       = 10,
  parameter int BUCKET_NBITS      = 64,
  parameter int VALUE_NBITS       = 280,
  parameter int VALUE_DEPTH_NBITS = 8,
  parameter int REG_ADDR_NBITS    = 32,
  parameter int REG_DATA_NBITS    = 64
);
  logic [REG_ADDR_NBITS-1:0]        reg_addr;
  logic [REG_DATA_NBITS-1:0]        reg_din;
  logic                             reg_rd;
  logic                             reg_wr;
  logic                             reg_ms_ekey_hash_table;
  logic                             reg_ms_ekey_value;
  logic                             ekey_hash_table_mem_ack;
  logic [REG_DATA_NBITS-1:0]        ekey_hash_table_mem_rdata;
  logic                             ekey_value_mem_ack;
  logic [REG_DATA_NBITS-1:0]        ekey_value_mem_rdata;
  logic                             ekey_value_stage_err;

  logic [N_WAYS-1:0]                ekey_hash_table_rd;
  logic [N_WAYS*DEPTH_NBITS-1:0]    ekey_hash_table_raddr;
  logic [N_WAYS-1:0]                ekey_hash_table_ack;
  logic [N_WAYS*BUCKET_NBITS-1:0]   ekey_hash_table_rdata;

  logic                             ekey_value_rd;
  logic [VALUE_DEPTH_NBITS-1:0]     ekey_value_raddr;
  logic                             ekey_value_wr;
  logic [VALUE_DEPTH_NBITS-1:0]     ekey_value_waddr;
  logic [VALUE_NBITS-1:0]           ekey_value_wdata;
  logic                             ekey_value_ack;
  logic [VALUE_NBITS-1:0]           ekey_value_rdata;

  modport master (
    output reg_addr, reg_din, reg_rd, reg_wr, reg_ms_ekey_hash_table, reg_ms_ekey_value,
    output ekey_hash_table_rd, ekey_hash_table_raddr,
    output ekey_value_rd, ekey_value_raddr, ekey_value_wr, ekey_value_waddr, ekey_value_wdata,
    input  ekey_hash_table_mem_ack, ekey_hash_table_mem_rdata,
    input  ekey_value_mem_ack, ekey_value_mem_rdata, ekey_value_stage_err,
    input  ekey_hash_table_ack, ekey_hash_table_rdata,
    input  ekey_value_ack, ekey_value_rdata
  );

  modport slave (
    input  reg_addr, reg_din, reg_rd, reg_wr, reg_ms_ekey_hash_table, reg_ms_ekey_value,
    input  ekey_hash_table_rd, ekey_hash_table_raddr,
    input  ekey_value_rd, ekey_value_raddr, ekey_value_wr, ekey_value_waddr, ekey_value_wdata,
    output ekey_hash_table_mem_ack, ekey_hash_table_mem_rdata,
    output ekey_value_mem_ack, ekey_value_mem_rdata, ekey_value_stage_err,
    output ekey_hash_table_ack, ekey_hash_table_rdata,
    output ekey_value_ack, ekey_value_rdata
  );
endinterface

// File: rtl/decap_mem_ekey_nway.sv
// N-way ekey hash-table buckets plus a wide value array, each with an app read port
// and a PIO port; value PIO writes are staged per lane and committed atomically.
module decap_mem_ekey_nway #(
  parameter int N_WAYS            = 4,
  parameter int DEPTH_NBITS       = 10,
  parameter int BUCKET_NBITS      = 64,
  parameter int VALUE_NBITS       = 280,
  parameter int VALUE_DEPTH_NBITS = 8,
  parameter int WM_NBITS          = 64,
  parameter int REG_ADDR_NBITS    = 32,
  parameter int REG_DATA_NBITS    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  decap_mem_ekey_nway_if.slave  bus
);
  localparam int LANES_RAW = (VALUE_NBITS + WM_NBITS - 1) / WM_NBITS;
  localparam int NUM_LANES = (LANES_RAW < 1) ? 1 : ((LANES_RAW > 8) ? 8 : LANES_RAW);
  localparam int WAY_NBITS = (N_WAYS > 1) ? $clog2(N_WAYS) : 1;
  localparam int QW_NBITS  = REG_ADDR_NBITS - 3;
  localparam int PAD_NBITS = (NUM_LANES * WM_NBITS > VALUE_NBITS) ? NUM_LANES * WM_NBITS : VALUE_NBITS;
  localparam int HT_DEPTH  = 1 << DEPTH_NBITS;
  localparam int VAL_DEPTH = 1 << VALUE_DEPTH_NBITS;
  localparam logic [NUM_LANES-1:0] MASK_FULL = NUM_LANES'((1 << (NUM_LANES - 1)) - 1);

  typedef enum logic [1:0] {IDLE, HT_ACC, VAL_ACC, RESP} state_t;

  state_t                         state;
  logic                           rq_wr;
  logic                           rq_ok;
  logic [WAY_NBITS-1:0]           rq_way;
  logic [DEPTH_NBITS-1:0]         rq_hidx;
  logic [VALUE_DEPTH_NBITS-1:0]   rq_vidx;
  logic [2:0]                     rq_lane;
  logic [REG_DATA_NBITS-1:0]      rq_din;
  logic [WM_NBITS-1:0]            shadow [NUM_LANES];
  logic [NUM_LANES-1:0]           stage_mask;
  logic                           stage_err;

  logic [QW_NBITS-1:0]            qw;
  logic                           ht_ok;
  logic                           val_ok;
  logic                           accept;
  logic                           unused_addr_lsb;

  assign qw              = bus.reg_addr[REG_ADDR_NBITS-1:3];
  assign unused_addr_lsb = ^bus.reg_addr[2:0];
  // Any qword bit above the index counts toward the way, so way N_WAYS is out of range.
  assign ht_ok  = (qw >> DEPTH_NBITS) < QW_NBITS'(N_WAYS);
  assign val_ok = ({1'b0, qw[2:0]} < 4'(NUM_LANES)) && ((qw >> (3 + VALUE_DEPTH_NBITS)) == '0);
  assign accept = (state == IDLE) && (bus.reg_rd || bus.reg_wr) &&
                  (bus.reg_ms_ekey_hash_table || bus.reg_ms_ekey_value);

  logic                           lane_last;
  logic [PAD_NBITS-1:0]           commit_pad;
  logic [PAD_NBITS-1:0]           val_pad_rd;
  logic [WM_NBITS-1:0]            val_lane_rd;
  logic                           val_b_we;
  logic [VALUE_DEPTH_NBITS-1:0]   val_b_addr;
  logic [VALUE_NBITS-1:0]         val_b_wdata;
  logic                           ht_b_we;
  logic [VALUE_NBITS-1:0]         val_mem [VAL_DEPTH];
  logic [BUCKET_NBITS-1:0]        ht_pio_rd [N_WAYS];
  logic [N_WAYS-1:0]              ht_ack_q;
  logic [N_WAYS*BUCKET_NBITS-1:0] ht_rdata_q;

  assign lane_last = (rq_lane == 3'(NUM_LANES - 1));

  always_comb begin
    commit_pad = '0;
    for (int k = 0; k < NUM_LANES - 1; k++)
      commit_pad[k*WM_NBITS +: WM_NBITS] = shadow[k];
    commit_pad[(NUM_LANES-1)*WM_NBITS +: WM_NBITS] = rq_din[WM_NBITS-1:0];
  end

  assign val_pad_rd  = PAD_NBITS'(val_mem[rq_vidx]);
  assign val_lane_rd = val_pad_rd[rq_lane*WM_NBITS +: WM_NBITS];

  // App writes own port B; the PIO commit only lands when it is free, and never under reset.
  always_comb begin
    val_b_we    = 1'b0;
    val_b_addr  = rq_vidx;
    val_b_wdata = commit_pad[VALUE_NBITS-1:0];
    if (bus.ekey_value_wr) begin
      val_b_we    = 1'b1;
      val_b_addr  = bus.ekey_value_waddr;
      val_b_wdata = bus.ekey_value_wdata;
    end else if (!rst && state == VAL_ACC && rq_wr && rq_ok && lane_last) begin
      val_b_we    = 1'b1;
    end
  end

  assign ht_b_we = !rst && (state == HT_ACC) && rq_wr && rq_ok;

  always_ff @(posedge clk) begin
    if (val_b_we)
      val_mem[val_b_addr] <= val_b_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ekey_value_ack   <= 1'b0;
      bus.ekey_value_rdata <= '0;
    end else begin
      bus.ekey_value_ack <= bus.ekey_value_rd;
      if (bus.ekey_value_rd)
        bus.ekey_value_rdata <= val_mem[bus.ekey_value_raddr];
    end
  end

  for (genvar w = 0; w < N_WAYS; w++) begin : g_way
    logic [BUCKET_NBITS-1:0] mem [HT_DEPTH];
    logic                    ack_r;
    logic [BUCKET_NBITS-1:0] rdata_r;

    always_ff @(posedge clk) begin
      if (ht_b_we && rq_way == WAY_NBITS'(w))
        mem[rq_hidx] <= rq_din[BUCKET_NBITS-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ack_r   <= 1'b0;
        rdata_r <= '0;
      end else begin
        ack_r <= bus.ekey_hash_table_rd[w];
        if (bus.ekey_hash_table_rd[w])
          rdata_r <= mem[bus.ekey_hash_table_raddr[w*DEPTH_NBITS +: DEPTH_NBITS]];
      end
    end

    assign ht_pio_rd[w]                                   = mem[rq_hidx];
    assign ht_ack_q[w]                                    = ack_r;
    assign ht_rdata_q[w*BUCKET_NBITS +: BUCKET_NBITS]     = rdata_r;
  end

  assign bus.ekey_hash_table_ack   = ht_ack_q;
  assign bus.ekey_hash_table_rdata = ht_rdata_q;
  assign bus.ekey_value_stage_err  = stage_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                         <= IDLE;
      rq_wr                         <= 1'b0;
      rq_ok                         <= 1'b0;
      rq_way                        <= '0;
      rq_hidx                       <= '0;
      rq_vidx                       <= '0;
      rq_lane                       <= '0;
      rq_din                        <= '0;
      stage_mask                    <= '0;
      stage_err                     <= 1'b0;
      for (int k = 0; k < NUM_LANES; k++)
        shadow[k] <= '0;
      bus.ekey_hash_table_mem_ack   <= 1'b0;
      bus.ekey_hash_table_mem_rdata <= '0;
      bus.ekey_value_mem_ack        <= 1'b0;
      bus.ekey_value_mem_rdata      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rq_wr   <= bus.reg_wr;
            rq_ok   <= bus.reg_ms_ekey_hash_table ? ht_ok : val_ok;
            rq_way  <= qw[DEPTH_NBITS +: WAY_NBITS];
            rq_hidx <= qw[DEPTH_NBITS-1:0];
            rq_lane <= qw[2:0];
            rq_vidx <= qw[3 +: VALUE_DEPTH_NBITS];
            rq_din  <= bus.reg_din;
            state   <= bus.reg_ms_ekey_hash_table ? HT_ACC : VAL_ACC;
          end
        end
        HT_ACC: begin
          bus.ekey_hash_table_mem_ack   <= 1'b1;
          bus.ekey_hash_table_mem_rdata <= (!rq_wr && rq_ok) ? REG_DATA_NBITS'(ht_pio_rd[rq_way]) : '0;
          state                         <= RESP;
        end
        VAL_ACC: begin
          if (!bus.ekey_value_wr) begin
            bus.ekey_value_mem_ack   <= 1'b1;
            bus.ekey_value_mem_rdata <= (!rq_wr && rq_ok) ? REG_DATA_NBITS'(val_lane_rd) : '0;
            if (rq_wr && rq_ok) begin
              if (lane_last) begin
                stage_mask <= '0;
                if (stage_mask != MASK_FULL)
                  stage_err <= 1'b1;
              end else begin
                shadow[rq_lane]     <= rq_din[WM_NBITS-1:0];
                stage_mask[rq_lane] <= 1'b1;
              end
            end
            state <= RESP;
          end
        end
        RESP: begin
          bus.ekey_hash_table_mem_ack   <= 1'b0;
          bus.ekey_hash_table_mem_rdata <= '0;
          bus.ekey_value_mem_ack        <= 1'b0;
          bus.ekey_value_mem_rdata      <= '0;
          state                         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
